// File: rtl/dm_arbiter.sv
// Data-memory arbiter: zero-fills the array after reset, then grants one
// access per cycle to m0 (CPU) or m1 (debug) with round-robin priority.
module dm_arbiter #(
  parameter int DEPTH = 3072,
  parameter int AW    = 12,
  parameter int DW    = 32
) (
  input  logic          clk,
  input  logic          reset,
  input  logic          m0_req,
  input  logic          m0_we,
  input  logic [AW-1:0] m0_addr,
  input  logic [DW-1:0] m0_wdata,
  input  logic [31:0]   m0_pc,
  output logic          m0_gnt,
  output logic          m0_rvalid,
  output logic [DW-1:0] m0_rdata,
  input  logic          m1_req,
  input  logic          m1_we,
  input  logic [AW-1:0] m1_addr,
  input  logic [DW-1:0] m1_wdata,
  input  logic [31:0]   m1_pc,
  output logic          m1_gnt,
  output logic          m1_rvalid,
  output logic [DW-1:0] m1_rdata,
  output logic          mem_we,
  output logic [AW-1:0] mem_addr,
  output logic [DW-1:0] mem_wd,
  output logic [31:0]   mem_pc,
  input  logic [DW-1:0] mem_rd,
  output logic          busy
);

  typedef enum logic {CLEAR = 1'b0, SERVE = 1'b1} state_t;

  localparam logic [AW:0]   DEPTH_L   = (AW+1)'(DEPTH);
  localparam logic [AW-1:0] LAST_ADDR = AW'(DEPTH - 1);

  state_t        state_r, next_state_s;
  logic [AW-1:0] clr_addr_r;
  logic          last_r;          // port granted most recently (0 = m0, 1 = m1)
  logic          in_range0_s, in_range1_s;

  assign in_range0_s = ({1'b0, m0_addr} < DEPTH_L);
  assign in_range1_s = ({1'b0, m1_addr} < DEPTH_L);

  // Next state, round-robin grant and memory-side mux
  always_comb begin
    next_state_s = state_r;
    m0_gnt       = 1'b0;
    m1_gnt       = 1'b0;
    mem_we       = 1'b0;
    mem_addr     = '0;
    mem_wd       = '0;
    mem_pc       = 32'h0000_0000;
    busy         = 1'b1;
    if (!reset) begin
      next_state_s = CLEAR;
    end else begin
      case (state_r)
        CLEAR: begin
          mem_we   = 1'b1;
          mem_addr = clr_addr_r;
          if (clr_addr_r == LAST_ADDR) begin
            next_state_s = SERVE;
          end else begin
            next_state_s = CLEAR;
          end
        end
        SERVE: begin
          busy = 1'b0;
          if (m0_req && m1_req) begin
            m0_gnt = last_r;
            m1_gnt = ~last_r;
          end else begin
            m0_gnt = m0_req;
            m1_gnt = m1_req;
          end
          if (m0_gnt) begin
            mem_we   = m0_we & in_range0_s;
            mem_addr = m0_addr;
            mem_wd   = m0_wdata;
            mem_pc   = m0_pc;
          end else if (m1_gnt) begin
            mem_we   = m1_we & in_range1_s;
            mem_addr = m1_addr;
            mem_wd   = m1_wdata;
            mem_pc   = m1_pc;
          end else begin
            mem_we   = 1'b0;
          end
        end
        default: begin
          next_state_s = CLEAR;
        end
      endcase
    end
  end

  // State, fill pointer, priority and registered read return
  always_ff @(posedge clk) begin
    if (!reset) begin
      state_r    <= CLEAR;
      clr_addr_r <= '0;
      last_r     <= 1'b1;
      m0_rvalid  <= 1'b0;
      m1_rvalid  <= 1'b0;
      m0_rdata   <= '0;
      m1_rdata   <= '0;
    end else begin
      state_r <= next_state_s;
      if (state_r == CLEAR) begin
        clr_addr_r <= clr_addr_r + 1'b1;
      end
      if (m0_gnt) begin
        last_r <= 1'b0;
      end else if (m1_gnt) begin
        last_r <= 1'b1;
      end
      m0_rvalid <= m0_gnt & ~m0_we;
      m1_rvalid <= m1_gnt & ~m1_we;
      // out-of-range reads return zero rather than whatever the array drives
      if (m0_gnt && !m0_we) begin
        m0_rdata <= in_range0_s ? mem_rd : '0;
      end
      if (m1_gnt && !m1_we) begin
        m1_rdata <= in_range1_s ? mem_rd : '0;
      end
    end
  end

endmodule

// File: tb/tb_dm_arbiter.sv
// Randomised bench for dm_arbiter: a behavioural memory/arbitration model
// predicts every output cycle by cycle; a plain array stands in for the dm.
module tb_dm_arbiter;
  localparam int DEPTH = 3072;
  localparam int AW    = 12;
  localparam int DW    = 32;

  logic clk = 1'b0;
  always #5 clk = ~clk;

  logic          reset;
  logic          m0_req, m0_we, m1_req, m1_we;
  logic [AW-1:0] m0_addr, m1_addr;
  logic [DW-1:0] m0_wdata, m1_wdata;
  logic [31:0]   m0_pc, m1_pc;
  logic          m0_gnt, m1_gnt, m0_rvalid, m1_rvalid;
  logic [DW-1:0] m0_rdata, m1_rdata;
  logic          mem_we, busy;
  logic [AW-1:0] mem_addr;
  logic [DW-1:0] mem_wd, mem_rd;
  logic [31:0]   mem_pc;

  dm_arbiter #(.DEPTH(DEPTH), .AW(AW), .DW(DW)) dut (
    .clk(clk), .reset(reset),
    .m0_req(m0_req), .m0_we(m0_we), .m0_addr(m0_addr), .m0_wdata(m0_wdata), .m0_pc(m0_pc),
    .m0_gnt(m0_gnt), .m0_rvalid(m0_rvalid), .m0_rdata(m0_rdata),
    .m1_req(m1_req), .m1_we(m1_we), .m1_addr(m1_addr), .m1_wdata(m1_wdata), .m1_pc(m1_pc),
    .m1_gnt(m1_gnt), .m1_rvalid(m1_rvalid), .m1_rdata(m1_rdata),
    .mem_we(mem_we), .mem_addr(mem_addr), .mem_wd(mem_wd), .mem_pc(mem_pc),
    .mem_rd(mem_rd), .busy(busy)
  );

  // Physical array: junk outside the valid range so zeroing is observable
  logic [DW-1:0] mem_arr [DEPTH];
  assign mem_rd = (int'(mem_addr) < DEPTH) ? mem_arr[mem_addr] : {20'hBAD00, mem_addr};
  always @(posedge clk) if (mem_we && int'(mem_addr) < DEPTH) mem_arr[mem_addr] <= mem_wd;

  // Reference model state
  logic [DW-1:0] ref_mem [DEPTH];
  int            fill_left = DEPTH;
  int            last_port = 1;
  bit            exp_rv [2];
  logic [DW-1:0] exp_rd [2];
  bit            pend [2];
  logic          obs_g0, obs_g1;
  int            n_checks = 0;
  int            n_fail   = 0;

  task automatic check_eq(input string tag, input logic [63:0] got, input logic [63:0] exp);
    n_checks++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0h expected %0h at %0t", tag, got, exp, $time);
    end
  endtask

  task automatic set_port(input int p, input logic q, input logic w, input logic [AW-1:0] a,
                          input logic [DW-1:0] d, input logic [31:0] pc);
    if (p == 0) begin
      m0_req = q; m0_we = w; m0_addr = a; m0_wdata = d; m0_pc = pc;
    end else begin
      m1_req = q; m1_we = w; m1_addr = a; m1_wdata = d; m1_pc = pc;
    end
  endtask

  function automatic logic [AW-1:0] pick_addr();
    int r;
    r = $urandom_range(0, 9);
    if (r < 6)      return AW'($urandom_range(0, 15));
    else if (r < 8) return AW'($urandom_range(3066, 3080));
    else            return AW'($urandom_range(3072, 4095));
  endfunction

  // Fresh random request per port unless an earlier one is still waiting
  task automatic rand_inputs();
    for (int p = 0; p < 2; p++)
      if (!pend[p])
        set_port(p, $urandom_range(0, 3) != 0, 1'($urandom_range(0, 1)), pick_addr(),
                 32'($urandom), 32'($urandom));
  endtask

  // One clock cycle: predict, check combinational outputs, advance, check registered outputs
  task automatic tick();
    logic          r [2];
    logic          w [2];
    logic [AW-1:0] a [2];
    logic [DW-1:0] d [2];
    logic [31:0]   p [2];
    int            g;
    logic          e_we, e_busy;
    logic [AW-1:0] e_addr;
    logic [DW-1:0] e_wd;
    logic [31:0]   e_pc;
    r[0] = m0_req; w[0] = m0_we; a[0] = m0_addr; d[0] = m0_wdata; p[0] = m0_pc;
    r[1] = m1_req; w[1] = m1_we; a[1] = m1_addr; d[1] = m1_wdata; p[1] = m1_pc;
    g = -1; e_we = 1'b0; e_busy = 1'b1; e_addr = '0; e_wd = '0; e_pc = 32'h0;
    #1;
    if (reset && fill_left > 0) begin
      e_we = 1'b1;
      e_addr = AW'(DEPTH - fill_left);
    end else if (reset) begin
      e_busy = 1'b0;
      if (r[0] && r[1]) g = (last_port == 1) ? 0 : 1;
      else if (r[0])    g = 0;
      else if (r[1])    g = 1;
      if (g >= 0) begin
        e_addr = a[g]; e_wd = d[g]; e_pc = p[g];
        e_we = w[g] && (int'(a[g]) < DEPTH);
      end
    end
    check_eq("busy",   64'(busy),   64'(e_busy));
    check_eq("m0_gnt", 64'(m0_gnt), 64'(g == 0));
    check_eq("m1_gnt", 64'(m1_gnt), 64'(g == 1));
    check_eq("mem_we", 64'(mem_we), 64'(e_we));
    if (reset) begin
      check_eq("mem_addr", 64'(mem_addr), 64'(e_addr));
      check_eq("mem_wd",   64'(mem_wd),   64'(e_wd));
      check_eq("mem_pc",   64'(mem_pc),   64'(e_pc));
    end
    obs_g0 = m0_gnt; obs_g1 = m1_gnt;
    @(posedge clk);
    exp_rv[0] = 1'b0; exp_rv[1] = 1'b0;
    if (!reset) begin
      fill_left = DEPTH; last_port = 1;
      exp_rd[0] = '0; exp_rd[1] = '0;
    end else if (fill_left > 0) begin
      ref_mem[DEPTH - fill_left] = '0;
      fill_left--;
    end else if (g >= 0) begin
      last_port = g;
      if (w[g]) begin
        if (int'(a[g]) < DEPTH) ref_mem[a[g]] = d[g];
      end else begin
        exp_rv[g] = 1'b1;
        exp_rd[g] = (int'(a[g]) < DEPTH) ? ref_mem[a[g]] : '0;
      end
    end
    for (int i = 0; i < 2; i++) pend[i] = r[i] && (g != i);
    #1;
    check_eq("m0_rvalid", 64'(m0_rvalid), 64'(exp_rv[0]));
    check_eq("m1_rvalid", 64'(m1_rvalid), 64'(exp_rv[1]));
    check_eq("m0_rdata",  64'(m0_rdata),  64'(exp_rd[0]));
    check_eq("m1_rdata",  64'(m1_rdata),  64'(exp_rd[1]));
    @(negedge clk);
  endtask

  // Count cycles with busy high after reset release; expect exactly DEPTH
  task automatic run_fill(input string tag);
    int cnt;
    cnt = 0;
    while (busy === 1'b1 && cnt < 4000) begin
      tick();
      cnt++;
    end
    check_eq(tag, 64'(cnt), 64'(DEPTH));
  endtask

  initial begin
    for (int i = 0; i < DEPTH; i++) begin
      mem_arr[i] = 32'($urandom) | 32'h1;
      ref_mem[i] = 32'hFFFF_FFFF;
    end
    exp_rd[0] = '0; exp_rd[1] = '0;
    pend[0] = 1'b0; pend[1] = 1'b0;
    set_port(0, 1'b0, 1'b0, '0, '0, 32'h0);
    set_port(1, 1'b0, 1'b0, '0, '0, 32'h0);
    reset = 1'b0;
    tick(); tick();
    reset = 1'b1;

    // Reset pulse when the fill pointer reaches 100, then a full fill
    for (int i = 0; i < 100; i++) tick();
    reset = 1'b0; tick(); reset = 1'b1;
    run_fill("fill_len_restart");

    // Both ports reading continuously: m0 first, then alternate
    set_port(0, 1'b1, 1'b0, 12'h001, '0, 32'h0);
    set_port(1, 1'b1, 1'b0, 12'h002, '0, 32'h0);
    for (int i = 0; i < 4; i++) begin
      tick();
      check_eq("contend_g0", 64'(obs_g0), 64'(i % 2 == 0));
      check_eq("contend_g1", 64'(obs_g1), 64'(i % 2 == 1));
    end
    set_port(1, 1'b0, 1'b0, '0, '0, 32'h0);

    // Read latency on address 5
    set_port(0, 1'b1, 1'b1, 12'h005, 32'h0000_1234, 32'h0000_2000); tick();
    set_port(0, 1'b1, 1'b0, 12'h005, '0, 32'h0000_2004);            tick();
    set_port(0, 1'b0, 1'b0, '0, '0, 32'h0);
    check_eq("lat_rdata", 64'(m0_rdata), 64'(32'h0000_1234));
    tick();
    check_eq("lat_rvalid_drop", 64'(m0_rvalid), 64'(1'b0));

    // Out-of-range write dropped, out-of-range read returns zero
    set_port(1, 1'b1, 1'b1, 12'hC00, 32'hDEAD_BEEF, 32'h0); tick();
    set_port(1, 1'b1, 1'b0, 12'hC00, '0, 32'h0);            tick();
    set_port(1, 1'b0, 1'b0, '0, '0, 32'h0);
    check_eq("oor_rdata", 64'(m1_rdata), 64'(32'h0));

    // Write by m0, read-back by m1 the next cycle
    set_port(0, 1'b1, 1'b1, 12'h010, 32'hCAFE_F00D, 32'h0000_3000); tick();
    set_port(0, 1'b0, 1'b0, '0, '0, 32'h0);
    set_port(1, 1'b1, 1'b0, 12'h010, '0, 32'h0);                     tick();
    set_port(1, 1'b0, 1'b0, '0, '0, 32'h0);
    check_eq("raw_rdata", 64'(m1_rdata), 64'(32'hCAFE_F00D));
    tick();

    for (int i = 0; i < 600; i++) begin
      rand_inputs();
      tick();
    end

    // Reset while a read return is pending, then a second full fill
    pend[0] = 1'b0; pend[1] = 1'b0;
    set_port(0, 1'b0, 1'b0, '0, '0, 32'h0);
    set_port(1, 1'b1, 1'b0, 12'h003, '0, 32'h0); tick();
    set_port(1, 1'b0, 1'b0, '0, '0, 32'h0);
    reset = 1'b0; tick(); reset = 1'b1;
    run_fill("fill_len_serve_reset");

    for (int i = 0; i < 200; i++) begin
      rand_inputs();
      tick();
    end

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end
endmodule
